// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - ALU reservation station
// Holds dispatched ALU/branch/jump ops until both operands resolve, then feeds the ALU one per cycle.
module alu_reservation_station #(
  parameter int RS_SIZE = 8,
  parameter int ENTRY_W = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               rob_clear,
  input  logic               issue_valid,
  input  logic [5:0]         issue_op,
  input  logic [31:0]        issue_instruction,
  input  logic [31:0]        issue_pc,
  input  logic [31:0]        issue_imm,
  input  logic [ENTRY_W-1:0] issue_entry,
  input  logic [31:0]        issue_vj,
  input  logic [31:0]        issue_vk,
  input  logic               issue_qj_busy,
  input  logic               issue_qk_busy,
  input  logic [ENTRY_W-1:0] issue_qj,
  input  logic [ENTRY_W-1:0] issue_qk,
  input  logic               alu_broadcast,
  input  logic [31:0]        alu_result,
  input  logic [ENTRY_W-1:0] alu_entry,
  input  logic               lsb_broadcast,
  input  logic [31:0]        lsb_result,
  input  logic [ENTRY_W-1:0] lsb_entry,
  output logic               rs_full,
  output logic               new_calculate,
  output logic [5:0]         alu_op,
  output logic [31:0]        alu_instruction,
  output logic [31:0]        alu_vj,
  output logic [31:0]        alu_vk,
  output logic [31:0]        alu_pc,
  output logic [31:0]        alu_imm,
  output logic [ENTRY_W-1:0] alu_entry_out
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] valid_q, valid_d;
  logic [RS_SIZE-1:0] qj_busy_q, qj_busy_d;
  logic [RS_SIZE-1:0] qk_busy_q, qk_busy_d;
  logic [5:0]         op_q    [RS_SIZE];
  logic [5:0]         op_d    [RS_SIZE];
  logic [31:0]        instr_q [RS_SIZE];
  logic [31:0]        instr_d [RS_SIZE];
  logic [31:0]        pc_q    [RS_SIZE];
  logic [31:0]        pc_d    [RS_SIZE];
  logic [31:0]        imm_q   [RS_SIZE];
  logic [31:0]        imm_d   [RS_SIZE];
  logic [31:0]        vj_q    [RS_SIZE];
  logic [31:0]        vj_d    [RS_SIZE];
  logic [31:0]        vk_q    [RS_SIZE];
  logic [31:0]        vk_d    [RS_SIZE];
  logic [ENTRY_W-1:0] tag_q   [RS_SIZE];
  logic [ENTRY_W-1:0] tag_d   [RS_SIZE];
  logic [ENTRY_W-1:0] qj_q    [RS_SIZE];
  logic [ENTRY_W-1:0] qj_d    [RS_SIZE];
  logic [ENTRY_W-1:0] qk_q    [RS_SIZE];
  logic [ENTRY_W-1:0] qk_d    [RS_SIZE];

  logic               new_calc_q, new_calc_d;
  logic [5:0]         out_op_q, out_op_d;
  logic [31:0]        out_instr_q, out_instr_d;
  logic [31:0]        out_vj_q, out_vj_d;
  logic [31:0]        out_vk_q, out_vk_d;
  logic [31:0]        out_pc_q, out_pc_d;
  logic [31:0]        out_imm_q, out_imm_d;
  logic [ENTRY_W-1:0] out_entry_q, out_entry_d;

  logic [RS_SIZE-1:0] ready;
  logic               free_found, disp_found;
  logic [IDX_W-1:0]   free_idx, disp_idx;

  // Returns {busy, value} after looking at both result buses; the ALU bus wins a double match.
  function automatic logic [32:0] snoop(
    input logic               busy,
    input logic [ENTRY_W-1:0] q,
    input logic [31:0]        v,
    input logic               ab,
    input logic [ENTRY_W-1:0] ae,
    input logic [31:0]        ar,
    input logic               lb,
    input logic [ENTRY_W-1:0] le,
    input logic [31:0]        lr
  );
    if (busy && ab && (ae == q)) return {1'b0, ar};
    if (busy && lb && (le == q)) return {1'b0, lr};
    return {busy, v};
  endfunction

  assign ready   = valid_q & ~qj_busy_q & ~qk_busy_q;
  assign rs_full = &valid_q;

  // Downward scans so the lowest matching index is the one left standing.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = i[IDX_W-1:0];
      end
      if (ready[i]) begin
        disp_found = 1'b1;
        disp_idx   = i[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    valid_d     = valid_q;
    qj_busy_d   = qj_busy_q;
    qk_busy_d   = qk_busy_q;
    op_d        = op_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    vj_d        = vj_q;
    vk_d        = vk_q;
    tag_d       = tag_q;
    qj_d        = qj_q;
    qk_d        = qk_q;
    new_calc_d  = 1'b0;
    out_op_d    = out_op_q;
    out_instr_d = out_instr_q;
    out_vj_d    = out_vj_q;
    out_vk_d    = out_vk_q;
    out_pc_d    = out_pc_q;
    out_imm_d   = out_imm_q;
    out_entry_d = out_entry_q;

    if (rob_clear) begin
      valid_d = '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (valid_q[i]) begin
          {qj_busy_d[i], vj_d[i]} = snoop(qj_busy_q[i], qj_q[i], vj_q[i], alu_broadcast,
                                          alu_entry, alu_result, lsb_broadcast, lsb_entry, lsb_result);
          {qk_busy_d[i], vk_d[i]} = snoop(qk_busy_q[i], qk_q[i], vk_q[i], alu_broadcast,
                                          alu_entry, alu_result, lsb_broadcast, lsb_entry, lsb_result);
        end
      end

      if (disp_found) begin
        new_calc_d          = 1'b1;
        out_op_d            = op_q[disp_idx];
        out_instr_d         = instr_q[disp_idx];
        out_vj_d            = vj_q[disp_idx];
        out_vk_d            = vk_q[disp_idx];
        out_pc_d            = pc_q[disp_idx];
        out_imm_d           = imm_q[disp_idx];
        out_entry_d         = tag_q[disp_idx];
        valid_d[disp_idx]   = 1'b0;
      end

      // free_idx only names a slot empty at cycle start, so it never collides with the dispatched one.
      if (issue_valid && free_found) begin
        valid_d[free_idx] = 1'b1;
        op_d[free_idx]    = issue_op;
        instr_d[free_idx] = issue_instruction;
        pc_d[free_idx]    = issue_pc;
        imm_d[free_idx]   = issue_imm;
        tag_d[free_idx]   = issue_entry;
        qj_d[free_idx]    = issue_qj;
        qk_d[free_idx]    = issue_qk;
        {qj_busy_d[free_idx], vj_d[free_idx]} = snoop(issue_qj_busy, issue_qj, issue_vj, alu_broadcast,
                                                      alu_entry, alu_result, lsb_broadcast, lsb_entry, lsb_result);
        {qk_busy_d[free_idx], vk_d[free_idx]} = snoop(issue_qk_busy, issue_qk, issue_vk, alu_broadcast,
                                                      alu_entry, alu_result, lsb_broadcast, lsb_entry, lsb_result);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q     <= '0;
      qj_busy_q   <= '0;
      qk_busy_q   <= '0;
      new_calc_q  <= 1'b0;
      out_op_q    <= '0;
      out_instr_q <= '0;
      out_vj_q    <= '0;
      out_vk_q    <= '0;
      out_pc_q    <= '0;
      out_imm_q   <= '0;
      out_entry_q <= '0;
    end else begin
      valid_q     <= valid_d;
      qj_busy_q   <= qj_busy_d;
      qk_busy_q   <= qk_busy_d;
      new_calc_q  <= new_calc_d;
      out_op_q    <= out_op_d;
      out_instr_q <= out_instr_d;
      out_vj_q    <= out_vj_d;
      out_vk_q    <= out_vk_d;
      out_pc_q    <= out_pc_d;
      out_imm_q   <= out_imm_d;
      out_entry_q <= out_entry_d;
    end
  end

  // Payload is only meaningful under valid, so it needs no reset.
  always_ff @(posedge clk_in) begin
    op_q    <= op_d;
    instr_q <= instr_d;
    pc_q    <= pc_d;
    imm_q   <= imm_d;
    vj_q    <= vj_d;
    vk_q    <= vk_d;
    tag_q   <= tag_d;
    qj_q    <= qj_d;
    qk_q    <= qk_d;
  end

  assign new_calculate   = new_calc_q;
  assign alu_op          = out_op_q;
  assign alu_instruction = out_instr_q;
  assign alu_vj          = out_vj_q;
  assign alu_vk          = out_vk_q;
  assign alu_pc          = out_pc_q;
  assign alu_imm         = out_imm_q;
  assign alu_entry_out   = out_entry_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - bench for alu_reservation_station
module tb_alu_reservation_station;

  localparam logic [5:0] OP_ADD = 6'd1;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, rob_clear, issue_valid;
  logic [5:0]  issue_op;
  logic [31:0] issue_instruction, issue_pc, issue_imm, issue_vj, issue_vk;
  logic [3:0]  issue_entry, issue_qj, issue_qk;
  logic        issue_qj_busy, issue_qk_busy;
  logic        alu_broadcast, lsb_broadcast;
  logic [31:0] alu_result, lsb_result;
  logic [3:0]  alu_entry, lsb_entry;
  logic        rs_full, new_calculate;
  logic [5:0]  alu_op;
  logic [31:0] alu_instruction, alu_vj, alu_vk, alu_pc, alu_imm;
  logic [3:0]  alu_entry_out;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  alu_reservation_station #(.RS_SIZE(8), .ENTRY_W(4)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_instruction(issue_instruction),
    .issue_pc(issue_pc), .issue_imm(issue_imm), .issue_entry(issue_entry),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj_busy(issue_qj_busy),
    .issue_qk_busy(issue_qk_busy), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .alu_broadcast(alu_broadcast), .alu_result(alu_result), .alu_entry(alu_entry),
    .lsb_broadcast(lsb_broadcast), .lsb_result(lsb_result), .lsb_entry(lsb_entry),
    .rs_full(rs_full), .new_calculate(new_calculate), .alu_op(alu_op),
    .alu_instruction(alu_instruction), .alu_vj(alu_vj), .alu_vk(alu_vk),
    .alu_pc(alu_pc), .alu_imm(alu_imm), .alu_entry_out(alu_entry_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a table of waiting instructions, oldest-slot-first selection.
  typedef struct {
    logic        v;
    logic [5:0]  op;
    logic [31:0] ins, pc, imm, vj, vk;
    logic [3:0]  ent, qj, qk;
    logic        bj, bk;
  } slot_t;

  slot_t       m [8];
  logic        mo_nc;
  logic [5:0]  mo_op;
  logic [31:0] mo_ins, mo_vj, mo_vk, mo_pc, mo_imm;
  logic [3:0]  mo_ent;
  int          md, mf;

  function automatic logic [32:0] wake(input logic busy, input logic [3:0] q, input logic [31:0] v);
    if (!busy) return {1'b0, v};
    if (alu_broadcast && alu_entry == q) return {1'b0, alu_result};
    if (lsb_broadcast && lsb_entry == q) return {1'b0, lsb_result};
    return {1'b1, v};
  endfunction

  function automatic logic model_full();
    for (int i = 0; i < 8; i++) if (!m[i].v) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst_in) begin
      for (int i = 0; i < 8; i++) m[i].v = 1'b0;
      mo_nc = 0; mo_op = 0; mo_ins = 0; mo_vj = 0; mo_vk = 0; mo_pc = 0; mo_imm = 0; mo_ent = 0;
    end else if (rob_clear) begin
      for (int i = 0; i < 8; i++) m[i].v = 1'b0;
      mo_nc = 0;
    end else if (!rdy_in) begin
      mo_nc = 0;
    end else begin
      md = -1;
      mf = -1;
      for (int i = 0; i < 8; i++) begin
        if (md < 0 && m[i].v && !m[i].bj && !m[i].bk) md = i;
        if (mf < 0 && !m[i].v) mf = i;
      end
      for (int i = 0; i < 8; i++) begin
        if (m[i].v) begin
          {m[i].bj, m[i].vj} = wake(m[i].bj, m[i].qj, m[i].vj);
          {m[i].bk, m[i].vk} = wake(m[i].bk, m[i].qk, m[i].vk);
        end
      end
      mo_nc = (md >= 0);
      if (md >= 0) begin
        mo_op = m[md].op; mo_ins = m[md].ins; mo_vj = m[md].vj; mo_vk = m[md].vk;
        mo_pc = m[md].pc; mo_imm = m[md].imm; mo_ent = m[md].ent;
        m[md].v = 1'b0;
      end
      if (issue_valid && mf >= 0) begin
        m[mf].v = 1'b1; m[mf].op = issue_op; m[mf].ins = issue_instruction;
        m[mf].pc = issue_pc; m[mf].imm = issue_imm; m[mf].ent = issue_entry;
        m[mf].qj = issue_qj; m[mf].qk = issue_qk;
        {m[mf].bj, m[mf].vj} = wake(issue_qj_busy, issue_qj, issue_vj);
        {m[mf].bk, m[mf].vk} = wake(issue_qk_busy, issue_qk, issue_vk);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("model_new_calculate", 32'(new_calculate), 32'(mo_nc));
      check("model_rs_full", 32'(rs_full), 32'(model_full()));
      check("model_alu_op", 32'(alu_op), 32'(mo_op));
      check("model_alu_instruction", alu_instruction, mo_ins);
      check("model_alu_vj", alu_vj, mo_vj);
      check("model_alu_vk", alu_vk, mo_vk);
      check("model_alu_pc", alu_pc, mo_pc);
      check("model_alu_imm", alu_imm, mo_imm);
      check("model_alu_entry_out", 32'(alu_entry_out), 32'(mo_ent));
    end
  end

  task automatic idle_inputs();
    rdy_in = 1; rob_clear = 0; issue_valid = 0; issue_op = 0; issue_instruction = 0;
    issue_pc = 0; issue_imm = 0; issue_entry = 0; issue_vj = 0; issue_vk = 0;
    issue_qj_busy = 0; issue_qk_busy = 0; issue_qj = 0; issue_qk = 0;
    alu_broadcast = 0; alu_result = 0; alu_entry = 0;
    lsb_broadcast = 0; lsb_result = 0; lsb_entry = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [3:0] ent, input logic [31:0] vj, input logic [31:0] vk,
                       input logic bj, input logic [3:0] qj, input logic bk, input logic [3:0] qk);
    issue_valid = 1; issue_op = OP_ADD; issue_entry = ent;
    issue_instruction = 32'h0000_0033 | (32'(ent) << 7);
    issue_pc = 32'h1000 + 32'(ent) * 4; issue_imm = 32'(ent);
    issue_vj = vj; issue_vk = vk;
    issue_qj_busy = bj; issue_qj = qj; issue_qk_busy = bk; issue_qk = qk;
  endtask

  task automatic bcast_alu(input logic [3:0] t, input logic [31:0] r);
    alu_broadcast = 1; alu_entry = t; alu_result = r;
  endtask

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    idle_inputs();
    rst_in = 1;
    cyc(); cyc();
    check("reset_new_calculate", 32'(new_calculate), 0);
    check("reset_rs_full", 32'(rs_full), 0);
    check("reset_alu_vj", alu_vj, 0);
    check("reset_alu_entry_out", 32'(alu_entry_out), 0);
    rst_in = 0;
    chk_en = 1;

    // Ready ADD: issue edge, dispatch on the following edge.
    issue(3, 5, 7, 0, 0, 0, 0);
    cyc(); check("t1_no_early_dispatch", 32'(new_calculate), 0);
    idle_inputs();
    cyc();
    check("t1_dispatch", 32'(new_calculate), 1);
    check("t1_vj", alu_vj, 5);
    check("t1_vk", alu_vk, 7);
    check("t1_entry", 32'(alu_entry_out), 3);
    check("t1_op", 32'(alu_op), 32'(OP_ADD));
    cyc();
    check("t1_pulse_one_cycle", 32'(new_calculate), 0);
    check("t1_vj_hold", alu_vj, 5);

    // Wakeup via ALU broadcast.
    issue(4, 0, 1, 1, 2, 0, 0);
    cyc(); idle_inputs();
    cyc();
    bcast_alu(2, 32'h10);
    cyc(); check("t2_woken_not_yet", 32'(new_calculate), 0);
    idle_inputs();
    cyc();
    check("t2_dispatch", 32'(new_calculate), 1);
    check("t2_vj", alu_vj, 32'h10);
    check("t2_entry", 32'(alu_entry_out), 4);
    cyc();

    // Issue bypass from the LSB bus.
    issue(5, 2, 0, 0, 0, 1, 6);
    lsb_broadcast = 1; lsb_entry = 6; lsb_result = 32'hABCD;
    cyc(); check("t3_no_early_dispatch", 32'(new_calculate), 0);
    idle_inputs();
    cyc();
    check("t3_dispatch", 32'(new_calculate), 1);
    check("t3_vk", alu_vk, 32'hABCD);
    check("t3_entry", 32'(alu_entry_out), 5);

    // Fill all slots blocked on tag 9.
    for (int i = 0; i < 8; i++) begin
      issue(4'(i), 0, 32'(i), 1, 9, 0, 0);
      cyc();
      if (i == 6) check("t4_not_full_at_7", 32'(rs_full), 0);
    end
    check("t4_full", 32'(rs_full), 1);
    issue(15, 1, 1, 0, 0, 0, 0);
    cyc();
    check("t4_full_hold", 32'(rs_full), 1);
    idle_inputs();
    cyc();
    check("t4_ninth_ignored", 32'(new_calculate), 0);
    bcast_alu(9, 32'h99);
    cyc();
    check("t4_woken_still_full", 32'(rs_full), 1);
    check("t4_woken_no_dispatch", 32'(new_calculate), 0);
    idle_inputs();
    issue(14, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 0) begin
        idle_inputs();
        check("t4_full_drops", 32'(rs_full), 0);
      end
      check("t4_drain_pulse", 32'(new_calculate), 1);
      check("t4_drain_order", 32'(alu_entry_out), 32'(i));
      check("t4_drain_vj", alu_vj, 32'h99);
      check("t4_drain_vk", alu_vk, 32'(i));
    end
    cyc();
    check("t4_drained", 32'(new_calculate), 0);

    // Flush with two ready and two blocked entries.
    issue(10, 0, 0, 1, 12, 0, 0); cyc();
    issue(11, 0, 0, 1, 12, 0, 0); cyc();
    issue(12, 0, 0, 0, 0, 1, 13); cyc();
    issue(13, 0, 0, 0, 0, 1, 13); cyc();
    idle_inputs();
    bcast_alu(12, 32'h12);
    cyc();
    check("t5_pre_clear", 32'(new_calculate), 0);
    idle_inputs();
    issue(1, 3, 3, 0, 0, 0, 0);
    rob_clear = 1;
    cyc();
    check("t5_clear_no_dispatch", 32'(new_calculate), 0);
    check("t5_clear_not_full", 32'(rs_full), 0);
    check("t5_fields_hold", 32'(alu_entry_out), 7);
    idle_inputs();
    lsb_broadcast = 1; lsb_entry = 13; lsb_result = 32'h13;
    cyc();
    check("t5_empty_a", 32'(new_calculate), 0);
    idle_inputs();
    cyc();
    check("t5_empty_b", 32'(new_calculate), 0);

    // Freeze with a ready entry and a matching broadcast.
    issue(8, 0, 0, 0, 0, 1, 10); cyc();
    issue(7, 32'h77, 32'h78, 0, 0, 0, 0); cyc();
    for (int i = 0; i < 3; i++) begin
      issue(6, 1, 1, 0, 0, 0, 0);
      bcast_alu(10, 32'h55);
      rdy_in = 0;
      cyc();
      check("t6_frozen", 32'(new_calculate), 0);
    end
    idle_inputs();
    cyc();
    check("t6_resume", 32'(new_calculate), 1);
    check("t6_resume_entry", 32'(alu_entry_out), 7);
    check("t6_resume_vj", alu_vj, 32'h77);
    cyc();
    check("t6_no_capture_while_frozen", 32'(new_calculate), 0);
    bcast_alu(10, 32'h66);
    cyc();
    check("t6_woken_wait", 32'(new_calculate), 0);
    idle_inputs();
    cyc();
    check("t6_late_dispatch", 32'(new_calculate), 1);
    check("t6_late_entry", 32'(alu_entry_out), 8);
    check("t6_late_vk", alu_vk, 32'h66);
    cyc();
    check("t6_end_idle", 32'(new_calculate), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Issue-side counterpart of the ALU: buffers decoded ALU/branch/jump instructions from the dispatcher until both operands are ready.
- Snoops the ALU and LSB broadcast buses to capture pending operands.
- Drives the ALU's one-cycle calculate pulse with operands, op, pc, imm, instruction and ROB entry tag.

Parameters:
- RS_SIZE, 8, number of entries (power of two, 2..16)
- ENTRY_W, 4, ROB tag width (matches `ENTRY_RANGE)

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global enable; low = freeze
- rob_clear  input  1  mispredict flush
- issue_valid  input  1  dispatcher writes one instruction this cycle
- issue_op  input  6  opcode (operaType encoding)
- issue_instruction  input  32  raw instruction (shamt source)
- issue_pc  input  32  instruction pc
- issue_imm  input  32  decoded immediate
- issue_entry  input  ENTRY_W  destination ROB tag
- issue_vj, issue_vk  input  32  operand values when not pending
- issue_qj_busy, issue_qk_busy  input  1  operand pending
- issue_qj, issue_qk  input  ENTRY_W  producer ROB tag when pending
- alu_broadcast  input  1  ALU result valid
- alu_result  input  32  ALU result
- alu_entry  input  ENTRY_W  ALU result tag
- lsb_broadcast  input  1  load result valid
- lsb_result  input  32  load result
- lsb_entry  input  ENTRY_W  load result tag
- rs_full  output  1  no free entry
- new_calculate  output  1  one-cycle ALU start pulse
- alu_op  output  6  op to ALU
- alu_instruction, alu_vj, alu_vk, alu_pc, alu_imm  output  32  fields to ALU
- alu_entry_out  output  ENTRY_W  ROB tag to ALU

Behaviour:
- Reset (rst_in high at edge): all entries invalid; new_calculate=0; all ALU output fields 0; rs_full=0.
- Priority at each edge: rst_in > rob_clear > rdy_in low > normal.
- rob_clear: all entries invalid; new_calculate=0; any issue in the same cycle is dropped; output fields hold.
- rdy_in low: no state change, no accept, no dispatch; new_calculate=0.
- rs_full: combinational, high iff all RS_SIZE entries are valid. issue_valid while rs_full is ignored (no overwrite, no state change).
- Allocation: the write goes to the lowest-index entry invalid at cycle start. A slot freed by dispatch in the same cycle is not reusable until the next cycle.
- Snoop (per edge, each valid entry, each operand): if busy and (alu_broadcast && alu_entry==q) or (lsb_broadcast && lsb_entry==q), capture the value and clear busy. If both buses match, ALU wins.
- Issue bypass: an incoming operand with busy set whose tag matches a broadcast in the same cycle is written already resolved, with the broadcast value.
- Ready: entry valid and both busy flags clear, evaluated on registered state at cycle start. Operands woken this edge are not eligible until the next cycle.
- Dispatch: each cycle, choose the lowest-index ready entry. At the edge: new_calculate=1, output fields = entry contents, entry invalidated. With no ready entry: new_calculate=0 and output fields hold.
- Latency: issue at edge N → earliest new_calculate high after edge N+1. Operand woken at edge N → earliest dispatch after edge N+1.
- Throughput: one dispatch and one issue per cycle, simultaneously.
- The unit never stalls on the ALU; the ALU is combinational and always accepts.
- Tags are compared at full ENTRY_W. No wrap-around concerns; the ROB guarantees unique in-flight tags.

Test Plan:
- Reset then issue ADD (op `ADD), vj=5, vk=7, no busy, entry=3 at edge 1 → new_calculate high for exactly the cycle after edge 2, alu_vj=5, alu_vk=7, alu_entry_out=3; entry freed.
- Issue with qj_busy, qj=2; two cycles later alu_broadcast, entry=2, result=0x10 → captured; dispatch with alu_vj=0x10 one cycle after the broadcast edge.
- Issue with qk_busy, qk=6 in the same cycle as lsb_broadcast entry=6, result=0xABCD → entry written ready; dispatch next cycle with alu_vk=0xABCD.
- Fill 8 entries, all blocked on tag 9 → rs_full=1; a 9th issue is ignored. Broadcast tag 9 → entries dispatch in index order 0..7 on consecutive cycles, one per cycle, and rs_full drops after the first dispatch.
- 4 entries valid, 2 ready; rob_clear asserted together with issue_valid → next cycle all invalid, new_calculate=0, rs_full=0, issued instruction absent.
- rdy_in low for 3 cycles with a ready entry and a matching broadcast → no dispatch, no capture; after rdy_in rises, dispatch proceeds normally.
